// File: rtl/mem_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_program_loader
//  Description : Collects a byte stream over valid/ready, packs it into
//                little-endian 32-bit words and writes them to the program
//                memory at consecutive word-aligned byte addresses.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_program_loader #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] addr_bus,
    output logic [31:0] data_bus,
    output logic        write_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // One bit wider than word_count so a depth of 1024 would still compare correctly
    localparam logic [10:0] c_depth = 11'(DEPTH_WORDS);

    state_t      r_state;
    logic [9:0]  r_count;
    logic [9:0]  r_index;
    logic [1:0]  r_byte_cnt;

    logic        w_count_bad;
    logic        w_byte_fire;
    logic [9:0]  w_index_next;

    assign w_count_bad  = (word_count == 10'd0) || ({1'b0, word_count} > c_depth);
    assign w_byte_fire  = byte_valid && byte_ready;
    assign w_index_next = r_index + 10'd1;

    // Loader FSM; every output is registered so the memory sees glitch-free strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= 10'd0;
            r_index      <= 10'd0;
            r_byte_cnt   <= 2'd0;
            byte_ready   <= 1'b0;
            addr_bus     <= BASE_ADDR;
            data_bus     <= 32'd0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (w_count_bad) begin
                            // Rejected request: flag it, forget any prior completion
                            error   <= 1'b1;
                            done    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_count    <= word_count;
                            r_index    <= 10'd0;
                            r_byte_cnt <= 2'd0;
                            addr_bus   <= BASE_ADDR;
                            done       <= 1'b0;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            r_state    <= S_COLLECT;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_byte_fire) begin
                        // Byte k lands in lane k (little-endian)
                        data_bus[{r_byte_cnt, 3'b000} +: 8] <= byte_in;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            byte_ready   <= 1'b0;
                            write_enable <= 1'b1;
                            r_state      <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    // Single-cycle strobe; addr/data stay put until the next word starts
                    write_enable <= 1'b0;
                    r_index      <= w_index_next;
                    if (w_index_next == r_count) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_byte_cnt <= 2'd0;
                        byte_ready <= 1'b1;
                        addr_bus   <= BASE_ADDR + {20'd0, w_index_next, 2'b00};
                        r_state    <= S_COLLECT;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_program_loader
//  Description : Self-checking bench for mem_program_loader. Two instances
//                (base 0x0 and base 0x100) share all stimulus; captured
//                writes are compared against words built from the byte list.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_program_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        byte_ready0, write_enable0, busy0, done0, error0;
    logic [31:0] addr_bus0, data_bus0;
    logic        byte_ready1, write_enable1, busy1, done1, error1;
    logic [31:0] addr_bus1, data_bus1;

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          rdy_in_write;
    bit          busy_seen;
    logic [63:0] wq0[$];
    logic [63:0] wq1[$];
    logic [7:0]  exp_bytes[$];

    mem_program_loader u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .word_count   (word_count),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready0),
        .addr_bus     (addr_bus0),
        .data_bus     (data_bus0),
        .write_enable (write_enable0),
        .busy         (busy0),
        .done         (done0),
        .error        (error0)
    );

    mem_program_loader #(
        .DEPTH_WORDS (512),
        .BASE_ADDR   (32'h0000_0100)
    ) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .word_count   (word_count),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready1),
        .addr_bus     (addr_bus1),
        .data_bus     (data_bus1),
        .write_enable (write_enable1),
        .busy         (busy1),
        .done         (done1),
        .error        (error1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe and watch for handshake violations
    always @(negedge clk) begin
        if (write_enable0) wq0.push_back({addr_bus0, data_bus0});
        if (write_enable1) wq1.push_back({addr_bus1, data_bus1});
        if (busy0 || busy1) busy_seen = 1'b1;
        if ((write_enable0 && byte_ready0) || (write_enable1 && byte_ready1))
            rdy_in_write = rdy_in_write + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, " ready"}, {31'd0, byte_ready0 | byte_ready1}, 32'd0);
        check_value({tag, " we"},    {31'd0, write_enable0 | write_enable1}, 32'd0);
        check_value({tag, " busy"},  {31'd0, busy0 | busy1}, 32'd0);
        check_value({tag, " done"},  {31'd0, done0 | done1}, 32'd0);
        check_value({tag, " error"}, {31'd0, error0 | error1}, 32'd0);
        check_value({tag, " addr0"}, addr_bus0, 32'h0000_0000);
        check_value({tag, " addr1"}, addr_bus1, 32'h0000_0100);
        check_value({tag, " data0"}, data_bus0, 32'd0);
    endtask

    task automatic fill_random(input int n_words);
        exp_bytes.delete();
        for (int i = 0; i < 4 * n_words; i++) exp_bytes.push_back(8'($urandom));
    endtask

    // Reference: word i is bytes 4i..4i+3 little-endian, at base + 4*i
    task automatic verify_writes(input string tag, input int n_words);
        check_value({tag, " nwr0"}, 32'(wq0.size()), 32'(n_words));
        check_value({tag, " nwr1"}, 32'(wq1.size()), 32'(n_words));
        for (int i = 0; i < n_words; i++) begin
            logic [31:0] ew;
            ew = {exp_bytes[4*i+3], exp_bytes[4*i+2], exp_bytes[4*i+1], exp_bytes[4*i]};
            if (i < wq0.size()) begin
                check_value({tag, " data0"}, wq0[i][31:0], ew);
                check_value({tag, " addr0"}, wq0[i][63:32], 32'(4 * i));
            end
            if (i < wq1.size()) begin
                check_value({tag, " data1"}, wq1[i][31:0], ew);
                check_value({tag, " addr1"}, wq1[i][63:32], 32'h100 + 32'(4 * i));
            end
        end
    endtask

    // mode 0: valid always high, 1: alternate cycles, 2: random gaps
    task automatic run_load(input int n_words, input int mode, input int spur_idx,
                            output int latency);
        int   idx;
        int   budget;
        int   start_cyc;
        int   w;
        logic v;
        logic rdy;
        bit   spur_done;
        idx       = 0;
        budget    = 0;
        spur_done = 1'b0;
        wq0.delete();
        wq1.delete();
        @(negedge clk);
        start      = 1'b1;
        word_count = n_words[9:0];
        start_cyc  = cyc;
        @(negedge clk);
        start = 1'b0;
        while (idx < 4 * n_words && budget < 40 * n_words + 100) begin
            if (spur_idx >= 0 && idx == spur_idx && !spur_done) begin
                start      = 1'b1;
                word_count = 10'd3;
                spur_done  = 1'b1;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = budget[0];
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            byte_valid = v;
            byte_in    = v ? exp_bytes[idx] : 8'($urandom);
            rdy        = byte_ready0;
            @(posedge clk);
            if (v && rdy) idx++;
            budget++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check_value("stream_complete", 32'(idx), 32'(4 * n_words));
        w = 0;
        while (!done0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_value("done_reached", {31'd0, done0}, 32'd1);
        latency = cyc - start_cyc;
    endtask

    initial begin
        int lat;
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        rdy_in_write = 0;
        busy_seen    = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        word_count   = 10'd0;
        byte_in      = 8'd0;
        byte_valid   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-word load, back-to-back bytes
        exp_bytes = '{8'h37, 8'h01, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        run_load(2, 0, -1, lat);
        verify_writes("basic", 2);
        check_value("basic w0", wq0[0][31:0], 32'h0000_0137);
        check_value("basic w1", wq0[1][31:0], 32'h0000_0013);
        check_value("basic done_cycle", 32'(lat), 32'd11);
        check_value("basic error", {31'd0, error0}, 32'd0);
        check_value("basic busy", {31'd0, busy0}, 32'd0);

        // Same load with the source stalling on alternate cycles
        rdy_in_write = 0;
        run_load(2, 1, -1, lat);
        verify_writes("stall", 2);
        check_value("stall rdy_in_write", 32'(rdy_in_write), 32'd0);

        // Rejected requests: zero and oversize counts
        for (int t = 0; t < 2; t++) begin
            wq0.delete();
            wq1.delete();
            busy_seen = 1'b0;
            @(negedge clk);
            start      = 1'b1;
            word_count = (t == 0) ? 10'd0 : 10'd513;
            @(negedge clk);
            start = 1'b0;
            check_value("reject error_next", {31'd0, error0 & error1}, 32'd1);
            check_value("reject done_clr", {31'd0, done0 | done1}, 32'd0);
            repeat (3) @(negedge clk);
            check_value("reject busy_seen", {31'd0, busy_seen}, 32'd0);
            check_value("reject writes", 32'(wq0.size() + wq1.size()), 32'd0);
            check_value("reject error_hold", {31'd0, error0}, 32'd1);
        end
        fill_random(1);
        run_load(1, 2, -1, lat);
        verify_writes("after_reject", 1);
        check_value("after_reject error", {31'd0, error0 | error1}, 32'd0);

        // Reset in the middle of a word
        wq0.delete();
        wq1.delete();
        @(negedge clk);
        start      = 1'b1;
        word_count = 10'd1;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        @(negedge clk);
        byte_in    = 8'hBB;
        @(negedge clk);
        byte_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_reset_values("midreset");
        repeat (2) @(negedge clk);
        check_value("midreset writes", 32'(wq0.size() + wq1.size()), 32'd0);
        rst_n = 1'b1;
        exp_bytes = '{8'hF0, 8'hCA, 8'hAC, 8'h0F};
        run_load(1, 0, -1, lat);
        verify_writes("post_reset", 1);
        check_value("post_reset word", wq0[0][31:0], 32'h0FAC_CAF0);

        // A few random loads with random gaps
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 6);
            fill_random(n);
            run_load(n, 2, -1, lat);
            verify_writes("random", n);
        end

        // Full depth with a spurious start mid-stream
        fill_random(512);
        run_load(512, 0, 1000, lat);
        verify_writes("full", 512);
        check_value("full last_addr0", wq0[wq0.size()-1][63:32], 32'h0000_07FC);
        check_value("full last_addr1", wq1[wq1.size()-1][63:32], 32'h0000_08FC);
        check_value("full done", {31'd0, done0 & done1}, 32'd1);

        // Three-word load: the base-0x100 instance must strobe 0x100/0x104/0x108
        fill_random(3);
        run_load(3, 2, -1, lat);
        verify_writes("base100", 3);
        check_value("total rdy_in_write", 32'(rdy_in_write), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute guard so the run always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
